// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// the elaboration-time parameter legality check.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // WIDTH must be a positive whole multiple of DIGIT.
  function automatic bit params_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/sub_digit_cell.sv
// Combinational DIGIT-bit ripple-borrow subtractor: diff = x - y - bi, bo = borrow out of the top bit.
module sub_digit_cell #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] diff,
  output logic             bo
);

  logic [DIGIT:0] chain;

  assign chain[0] = bi;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign diff[gi]    = x[gi] ^ y[gi] ^ chain[gi];
    assign chain[gi+1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & chain[gi]);
  end

  assign bo = chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor D = A - B - BIN, DIGIT bits per clock with start/done handshake.
// Define SUB_SAT_EN to clamp d to zero whenever the final borrow is set.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;
  logic             bo_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [DIGIT-1:0] cell_diff;
  logic             cell_bo;
  logic [WIDTH-1:0] r_shift;

  sub_digit_cell #(.DIGIT(DIGIT)) u_cell (
    .x    (a_sh_reg[DIGIT-1:0]),
    .y    (b_sh_reg[DIGIT-1:0]),
    .bi   (borrow_reg),
    .diff (cell_diff),
    .bo   (cell_bo)
  );

  // New digit enters the result from the MSB side, so after STEPS shifts it is aligned.
  if (WIDTH == DIGIT) begin : g_single_step
    assign r_shift = cell_diff;
  end else begin : g_multi_step
    assign r_shift = {cell_diff, r_reg[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      r_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bo_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> DIGIT;
          b_sh_reg   <= b_sh_reg >> DIGIT;
          r_reg      <= r_shift;
          borrow_reg <= cell_bo;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_STEP) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            bo_reg    <= cell_bo;
`ifdef SUB_SAT_EN
            d_reg     <= cell_bo ? '0 : r_shift;
`else
            d_reg     <= r_shift;
`endif
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign d    = d_reg;
  assign bo   = bo_reg;

endmodule
